// File: rtl/hazard_ctrl_sb_pkg.sv
// Shared opcode constants and register-use decode for the hazard controller.
package hazard_ctrl_sb_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op == OPCODE_OP || op == OPCODE_OP_IMM ||
           op == OPCODE_LOAD || op == OPCODE_STORE ||
           op == OPCODE_BRANCH || op == OPCODE_JALR;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OPCODE_OP || op == OPCODE_STORE ||
           op == OPCODE_BRANCH;
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return op == OPCODE_OP || op == OPCODE_OP_IMM ||
           op == OPCODE_LOAD || op == OPCODE_JAL ||
           op == OPCODE_JALR || op == OPCODE_LUI ||
           op == OPCODE_AUIPC;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_scoreboard.sv
// Per-register pending state: load countdowns and long-op busy bits.
// x0 is never marked, so lookups of x0 always report not pending.
module hazard_scoreboard #(
  parameter int RA_W     = 5,
  parameter int NREG     = 32,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            set_cnt,
  input  logic            set_lb,
  input  logic [RA_W-1:0] set_rd,
  input  logic            clr_lb,
  input  logic [RA_W-1:0] clr_rd,
  input  logic [RA_W-1:0] ra1,
  input  logic [RA_W-1:0] ra2,
  input  logic [RA_W-1:0] ra3,
  output logic            pend1,
  output logic            pend2,
  output logic            pend3,
  output logic            lb_clr
);

  logic [2:0]      cnt [NREG];
  logic [NREG-1:0] lb;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= 3'd0;
      lb <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (set_cnt && set_rd == RA_W'(r))
          cnt[r] <= 3'(LOAD_LAT);
        else if (!hold && cnt[r] != 3'd0)
          cnt[r] <= cnt[r] - 3'd1;
        // a new long op on the same register outlives the completing one
        if (set_lb && set_rd == RA_W'(r))
          lb[r] <= 1'b1;
        else if (clr_lb && clr_rd == RA_W'(r))
          lb[r] <= 1'b0;
      end
    end
  end

  function automatic logic pend(input logic [RA_W-1:0] a);
    return a != '0 && (cnt[a] != 3'd0 || lb[a]);
  endfunction

  always_comb begin
    pend1  = pend(ra1);
    pend2  = pend(ra2);
    pend3  = pend(ra3);
    lb_clr = lb[clr_rd];
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller: stall/kill/freeze priority, long-op
// occupancy and stall counter around the register scoreboard.
module hazard_ctrl_sb
  import hazard_ctrl_sb_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int NREG     = 32,
  parameter int LOAD_LAT = 1,
  parameter int MAX_LONG = 1,
  parameter int M_EXT    = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [6:0]       id_funct7,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_redirect,
  input  logic             mem_req_pending,
  input  logic             mem_ready,
  input  logic             lo_done,
  input  logic [RA_W-1:0]  lo_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             if_kill,
  output logic             dec_kill,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_count
);

  localparam int LO_W = $clog2(MAX_LONG + 1);

  logic [LO_W-1:0] lo_cnt;
  logic p1, p2, p3, lb_hit;
  logic frz, stall, issue, is_long, is_load;
  logic set_cnt, set_lb, lo_dec;

  assign frz     = mem_req_pending & ~mem_ready;
  assign is_load = id_opcode == OPCODE_LOAD;
  assign is_long = (M_EXT != 0) && id_opcode == OPCODE_OP &&
                   id_funct7 == FUNCT7_MULDIV;

  assign stall = id_valid & (
    (uses_rs1(id_opcode) & p1) |
    (uses_rs2(id_opcode) & p2) |
    (writes_rd(id_opcode) & p3) |
    (is_long & (lo_cnt == LO_W'(MAX_LONG))));

  assign issue   = id_valid & ~stall & ~frz & ~ex_redirect;
  assign set_cnt = issue & is_load & (id_rd != '0);
  // long ops to x0 are never tracked, so they never occupy a slot
  assign set_lb  = issue & is_long & (id_rd != '0);
  assign lo_dec  = lo_done & lb_hit;

  hazard_scoreboard #(
    .RA_W     (RA_W),
    .NREG     (NREG),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .hold    (frz),
    .set_cnt (set_cnt),
    .set_lb  (set_lb),
    .set_rd  (id_rd),
    .clr_lb  (lo_done),
    .clr_rd  (lo_rd),
    .ra1     (id_rs1),
    .ra2     (id_rs2),
    .ra3     (id_rd),
    .pend1   (p1),
    .pend2   (p2),
    .pend3   (p3),
    .lb_clr  (lb_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_cnt <= '0;
    end else begin
      case ({set_lb, lo_dec})
        2'b10:   lo_cnt <= lo_cnt + LO_W'(1);
        2'b01:   lo_cnt <= lo_cnt - LO_W'(1);
        default: lo_cnt <= lo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (frz | (stall & ~ex_redirect))
      stall_count <= stall_count + CNT_W'(1);
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    if_kill     = 1'b0;
    dec_kill    = 1'b0;
    freeze      = 1'b0;
    priority case (1'b1)
      rst: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if_kill     = 1'b1;
        dec_kill    = 1'b1;
      end
      frz: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        freeze     = 1'b1;
      end
      ex_redirect: begin
        idex_bubble = 1'b1;
        if_kill     = 1'b1;
        dec_kill    = 1'b1;
      end
      stall: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Scoreboard bench: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_hazard_ctrl_sb;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] F_MD = 7'b0000001;
  localparam logic [6:0] F_SB = 7'b0100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [6:0] id_opcode = '0, id_funct7 = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic ex_redirect = 1'b0;
  logic mem_req_pending = 1'b0, mem_ready = 1'b1;
  logic lo_done = 1'b0;
  logic [4:0] lo_rd = '0;

  logic a_pc, a_if, a_bub, a_ik, a_dk, a_fz;
  logic b_pc, b_if, b_bub, b_ik, b_dk, b_fz;
  logic [31:0] a_sc, b_sc;

  always #5 clk = ~clk;

  hazard_ctrl_sb #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect),
    .mem_req_pending(mem_req_pending), .mem_ready(mem_ready),
    .lo_done(lo_done), .lo_rd(lo_rd),
    .pc_write(a_pc), .ifid_write(a_if), .idex_bubble(a_bub),
    .if_kill(a_ik), .dec_kill(a_dk), .freeze(a_fz),
    .stall_count(a_sc)
  );

  hazard_ctrl_sb #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect),
    .mem_req_pending(mem_req_pending), .mem_ready(mem_ready),
    .lo_done(lo_done), .lo_rd(lo_rd),
    .pc_write(b_pc), .ifid_write(b_if), .idex_bubble(b_bub),
    .if_kill(b_ik), .dec_kill(b_dk), .freeze(b_fz),
    .stall_count(b_sc)
  );

  typedef struct {
    bit          sel;
    byte         mode;
    logic [5:0]  o;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int idx = 0;
  logic [31:0] exp_sc [2];

  function automatic logic [5:0] out_of(input byte m);
    case (m)
      "N":     return 6'b110000;
      "S":     return 6'b001000;
      "R":     return 6'b111110;
      "F":     return 6'b000001;
      default: return 6'b001110;
    endcase
  endfunction

  task automatic cyc(input byte m, input bit s);
    exp_t e;
    e.sel = s; e.mode = m; e.o = out_of(m); e.sc = exp_sc[s];
    q.push_back(e);
    if (m == "X") begin
      exp_sc[0] = 0; exp_sc[1] = 0;
    end else if (m == "S" || m == "F") begin
      exp_sc[s] = exp_sc[s] + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic ins(input logic [6:0] op, input logic [6:0] f7,
                     input int rd, input int r1, input int r2);
    id_valid = 1'b1; id_opcode = op; id_funct7 = f7;
    id_rd = 5'(rd); id_rs1 = 5'(r1); id_rs2 = 5'(r2);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_opcode = '0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      logic [31:0] asc;
      e = q.pop_front();
      act = e.sel ? {b_pc, b_if, b_bub, b_ik, b_dk, b_fz}
                  : {a_pc, a_if, a_bub, a_ik, a_dk, a_fz};
      asc = e.sel ? b_sc : a_sc;
      total++;
      if (act !== e.o || asc !== e.sc) begin
        bad++;
        $display("FAIL step%0d mode=%s dut%0d: got out=%b cnt=%0d want out=%b cnt=%0d",
                 idx, e.mode, e.sel, act, asc, e.o, e.sc);
      end
      idx++;
    end
  end

  initial begin
    exp_sc[0] = 0; exp_sc[1] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    // load-use, LOAD_LAT=1
    ins(LD, 0, 5, 1, 0);      cyc("N", 0);
    ins(OP, 0, 6, 5, 1);      cyc("S", 0);
                              cyc("N", 0);
    // long op dependency
    ins(OP, F_MD, 7, 2, 3);   cyc("N", 0);
    ins(OP, F_SB, 8, 7, 1);   cyc("S", 0);
                              cyc("S", 0);
    lo_done = 1; lo_rd = 7;   cyc("S", 0);
    lo_done = 0;              cyc("N", 0);
    // structural stall on second long op
    ins(OP, F_MD, 10, 1, 2);  cyc("N", 0);
    ins(OP, F_MD, 11, 1, 2);  cyc("S", 0);
    lo_done = 1; lo_rd = 10;  cyc("S", 0);
    lo_done = 0;              cyc("N", 0);
    idle(); lo_done = 1; lo_rd = 11; cyc("N", 0);
    lo_done = 0;
    // redirect during stall kills without scoreboard set
    ins(LD, 0, 5, 1, 0);      cyc("N", 0);
    ins(LD, 0, 12, 5, 0); ex_redirect = 1; cyc("R", 0);
    ex_redirect = 0;
    ins(OP, 0, 13, 12, 0);    cyc("N", 0);
    // freeze holds the load countdown
    ins(LD, 0, 5, 1, 0);      cyc("N", 0);
    ins(OP, 0, 6, 5, 1);
    mem_req_pending = 1; mem_ready = 0;
                              cyc("F", 0);
    lo_done = 1; lo_rd = 9;   cyc("F", 0);
    lo_done = 0;              cyc("F", 0);
                              cyc("F", 0);
    mem_req_pending = 0; mem_ready = 1;
                              cyc("S", 0);
                              cyc("N", 0);
    // redirect masked by freeze, then presented
    idle(); ex_redirect = 1;
    mem_req_pending = 1; mem_ready = 0; cyc("F", 0);
    mem_req_pending = 0; mem_ready = 1; cyc("R", 0);
    ex_redirect = 0;
    // x0 never pending
    ins(LD, 0, 0, 1, 0);      cyc("N", 0);
    ins(OP, 0, 1, 0, 0);      cyc("N", 0);
    // stray lo_done must not underflow occupancy
    idle(); lo_done = 1; lo_rd = 9; cyc("N", 0);
    lo_done = 0;
    ins(OP, F_MD, 9, 1, 2);   cyc("N", 0);
    ins(OP, F_MD, 14, 1, 2);  cyc("S", 0);
    idle(); lo_done = 1; lo_rd = 9; cyc("N", 0);
    lo_done = 0;
    rst = 1;                  cyc("X", 0);
    rst = 0;
    // LOAD_LAT=3 instance
    ins(LD, 0, 5, 1, 0);      cyc("N", 1);
    ins(OP, 0, 6, 5, 1);      cyc("S", 1);
                              cyc("S", 1);
                              cyc("S", 1);
                              cyc("N", 1);
    ins(LD, 0, 5, 1, 0);      cyc("N", 1);
    ins(OP, F_MD, 7, 1, 2);   cyc("N", 1);
    idle(); rst = 1;          cyc("X", 1);
    rst = 0;
    ins(OP, 0, 6, 5, 7);      cyc("N", 1);
                              cyc("N", 1);
    idle();
    repeat (4) begin
      if (q.size() > 0) @(negedge clk);
    end
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
